// File: rtl/biquad_cascade.sv
// Cascade of NBANDS Direct Form I biquad sections sharing one signed
// multiplier. Each sample spends five cycles per band (b0,b1,b2,a1,a2
// terms). Coefficients are written into a shadow bank and copied to the
// active bank only while idle, so a sample never sees a half-updated filter.
module biquad_cascade #(
   parameter int NBANDS = 4,
   parameter int DW     = 32,
   parameter int QF     = 15,
   localparam int BW    = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DW-1:0]     i_data,
   output logic              o_ready,
   output logic              o_valid,
   output logic [DW-1:0]     o_data,
   input  logic [NBANDS-1:0] i_band_en,
   input  logic              i_coef_we,
   input  logic [BW-1:0]     i_coef_band,
   input  logic [2:0]        i_coef_sel,
   input  logic [DW-1:0]     i_coef_data,
   input  logic              i_coef_commit
);

   localparam int AW = 2*DW + 3;
   localparam logic [DW-1:0] C_UNITY = DW'(1) << QF;
   localparam logic [DW-1:0] C_MAX   = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] C_MIN   = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   // Coefficient banks, index 0..4 = b0, b1, b2, a1, a2
   logic [DW-1:0] r_shadow [NBANDS][5];
   logic [DW-1:0] r_active [NBANDS][5];
   logic          r_pending;
   logic          w_copy;

   // Per-band Direct Form I histories
   logic [DW-1:0] r_x1 [NBANDS];
   logic [DW-1:0] r_x2 [NBANDS];
   logic [DW-1:0] r_y1 [NBANDS];
   logic [DW-1:0] r_y2 [NBANDS];

   logic [DW-1:0]        r_x;
   logic [BW-1:0]        r_band;
   logic [2:0]           r_step;
   logic                 r_bypass;
   logic signed [AW-1:0] r_acc;
   logic [DW-1:0]        r_dataOut;

   logic signed [DW-1:0]   w_coef;
   logic signed [DW-1:0]   w_operand;
   logic signed [2*DW-1:0] w_prod;
   logic signed [AW-1:0]   w_prodExt;
   logic signed [AW-1:0]   w_accNext;
   logic signed [AW-1:0]   w_shift;
   logic [AW-DW:0]         w_upper;
   logic [DW-1:0]          w_sat;
   logic [DW-1:0]          w_bandY;
   logic                   w_lastBand;

   assign w_lastBand = (r_band == BW'(NBANDS-1));
   assign w_copy     = (r_state == S_IDLE) && r_pending;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_stateNext;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_stateNext = r_state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) w_stateNext = S_MAC;
         end
         S_MAC: begin
            if (r_step == 3'd4 && w_lastBand) w_stateNext = S_OUT;
         end
         S_OUT: begin
            o_valid     = 1'b1;
            w_stateNext = S_IDLE;
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Pick the coefficient and data operand for the current MAC step
   always_comb begin
      w_coef    = r_active[r_band][0];
      w_operand = r_x;
      case (r_step)
         3'd1: begin
            w_coef    = r_active[r_band][1];
            w_operand = r_x1[r_band];
         end
         3'd2: begin
            w_coef    = r_active[r_band][2];
            w_operand = r_x2[r_band];
         end
         3'd3: begin
            w_coef    = r_active[r_band][3];
            w_operand = r_y1[r_band];
         end
         3'd4: begin
            w_coef    = r_active[r_band][4];
            w_operand = r_y2[r_band];
         end
         default: begin
            w_coef    = r_active[r_band][0];
            w_operand = r_x;
         end
      endcase
   end

   assign w_prod    = (2*DW)'(w_coef) * (2*DW)'(w_operand);
   assign w_prodExt = AW'(w_prod);

   // Accumulate feed-forward terms, subtract feedback terms
   always_comb begin
      w_accNext = w_prodExt;
      case (r_step)
         3'd0:       w_accNext = w_prodExt;
         3'd1, 3'd2: w_accNext = r_acc + w_prodExt;
         default:    w_accNext = r_acc - w_prodExt;
      endcase
   end

   assign w_shift = w_accNext >>> QF;
   assign w_upper = w_shift[AW-1:DW-1];

   // Saturate the floor-shifted accumulator to the sample range
   always_comb begin
      w_sat = w_shift[DW-1:0];
      if (!((&w_upper) || (~|w_upper))) begin
         w_sat = w_shift[AW-1] ? C_MIN : C_MAX;
      end
   end

   assign w_bandY = r_bypass ? r_x : w_sat;

   // Sample datapath: accept, MAC sequencing, history shift, output capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x       <= '0;
         r_band    <= '0;
         r_step    <= '0;
         r_bypass  <= 1'b0;
         r_acc     <= '0;
         r_dataOut <= '0;
         for (int b = 0; b < NBANDS; b++) begin
            r_x1[b] <= '0;
            r_x2[b] <= '0;
            r_y1[b] <= '0;
            r_y2[b] <= '0;
         end
      end else if (r_state == S_IDLE) begin
         if (i_valid) begin
            r_x    <= i_data;
            r_band <= '0;
            r_step <= '0;
         end
      end else if (r_state == S_MAC) begin
         r_acc <= w_accNext;
         if (r_step == 3'd0) r_bypass <= ~i_band_en[r_band];
         if (r_step == 3'd4) begin
            r_step <= '0;
            r_x    <= w_bandY;
            if (!r_bypass) begin
               r_x2[r_band] <= r_x1[r_band];
               r_x1[r_band] <= r_x;
               r_y2[r_band] <= r_y1[r_band];
               r_y1[r_band] <= w_sat;
            end
            if (w_lastBand) r_dataOut <= w_bandY;
            else            r_band    <= r_band + BW'(1);
         end else begin
            r_step <= r_step + 3'd1;
         end
      end
   end

   assign o_data = r_dataOut;

   // Shadow writes, commit request flag and idle-time bank copy
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pending <= 1'b0;
         for (int b = 0; b < NBANDS; b++) begin
            for (int s = 0; s < 5; s++) begin
               r_shadow[b][s] <= (s == 0) ? C_UNITY : '0;
               r_active[b][s] <= (s == 0) ? C_UNITY : '0;
            end
         end
      end else begin
         if (i_coef_commit)  r_pending <= 1'b1;
         else if (w_copy)    r_pending <= 1'b0;
         if (w_copy) begin
            for (int b = 0; b < NBANDS; b++) begin
               for (int s = 0; s < 5; s++) begin
                  r_active[b][s] <= r_shadow[b][s];
               end
            end
         end
         if (i_coef_we) begin
            for (int b = 0; b < NBANDS; b++) begin
               for (int s = 0; s < 5; s++) begin
                  if (i_coef_band == BW'(b) && i_coef_sel == 3'(s)) begin
                     r_shadow[b][s] <= i_coef_data;
                  end
               end
            end
         end
      end
   end

endmodule

// File: doc/biquad_cascade.md
BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 SHALL have parameter NBANDS, default 4, number of cascaded biquad sections (1..16).
REQ-002 SHALL have parameter DW, default 32, sample and coefficient width (signed two's complement).
REQ-003 SHALL have parameter QF, default 15, fractional bits of the fixed-point format.
REQ-004 SHALL have port i_clk  input  1  clock.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  input  1  input sample strobe.
REQ-007 SHALL have port i_data  input  DW  input sample.
REQ-008 SHALL have port o_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse, o_data holds a new sample.
REQ-010 SHALL have port o_data  output  DW  filtered sample, held until the next o_valid.
REQ-011 SHALL have port i_band_en  input  NBANDS  per-band enable; a 0 bit bypasses that band.
REQ-012 SHALL have port i_coef_we  input  1  shadow coefficient write strobe.
REQ-013 SHALL have port i_coef_band  input  $clog2(NBANDS) (min 1)  target band of the write.
REQ-014 SHALL have port i_coef_sel  input  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; codes 5-7 are ignored.
REQ-015 SHALL have port i_coef_data  input  DW  coefficient value, same Q format as the samples.
REQ-016 SHALL have port i_coef_commit  input  1  request to copy the shadow bank to the active bank.

Function
REQ-017 Each band SHALL compute Direct Form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, with a0 normalised to 1.
REQ-018 Band k output SHALL be band k+1 input; band NBANDS-1 output SHALL drive o_data.
REQ-019 SHALL use a single shared DW x DW signed multiplier, time-multiplexed, one product per cycle.
REQ-020 Products SHALL be full 2*DW bits; the accumulator SHALL be 2*DW+3 bits; no intermediate truncation.
REQ-021 Band result SHALL be the accumulator arithmetically shifted right by QF, truncated toward minus infinity, then saturated to the DW signed range.
REQ-022 The saturated band result SHALL be the value stored into that band's y1 history.
REQ-023 FSM states: S_IDLE, S_MAC, S_OUT.
REQ-024 S_IDLE: o_ready=1; i_valid=1 latches i_data, sets band=0, step=0, and goes to S_MAC.
REQ-025 S_MAC: 5 cycles per band (step 0..4 = b0,b1,b2,a1,a2 terms); on step 4 the band histories shift (x2<=x1, x1<=x, y2<=y1, y1<=y); band increments; after the last band goes to S_OUT.
REQ-026 S_OUT: o_valid=1 for one cycle, o_data updated in the same cycle, then return to S_IDLE.
REQ-027 Latency from accept to o_valid SHALL be exactly 5*NBANDS+1 cycles, independent of i_band_en.
REQ-028 o_ready SHALL be 0 in S_MAC and S_OUT; i_valid while o_ready=0 SHALL be ignored and not queued.
REQ-029 Bypassed band (i_band_en[k]=0, sampled at band start): still consumes 5 cycles, passes y=x unchanged, and freezes its x/y histories.
REQ-030 i_coef_we SHALL write the shadow bank in any state, without affecting the active bank.
REQ-031 i_coef_commit SHALL set a pending flag; the active bank SHALL load from the shadow bank on the first cycle in S_IDLE with the flag set, and the flag then clears.
REQ-032 A commit taking effect in the same cycle as an accept SHALL apply to that sample.
REQ-033 A write and a commit in the same cycle SHALL include the write in the committed bank.
REQ-034 A write in the same cycle as the commit copy SHALL land in the shadow bank only.
REQ-035 The active bank SHALL never change during S_MAC.

Reset
REQ-036 On i_rst: state=S_IDLE, o_ready=1, o_valid=0, o_data=0, pending flag=0.
REQ-037 On i_rst: all histories=0; active and shadow b0=1<<QF; all other coefficients=0 (identity filter).
REQ-038 A reset mid-S_MAC SHALL abort the sample with no o_valid.

Verification
REQ-039 Identity: after reset, NBANDS=4, QF=15, input 12345 -> o_valid exactly 21 cycles after accept, o_data=12345.
REQ-040 Impulse: band0 b0=0.5, b1=0.25 (16384, 8192), others identity, committed; inputs 32768, 0, 0 -> outputs 16384, 8192, 0.
REQ-041 Feedback: band0 b0=1, a1=-0.5 (-16384); inputs 32768, 0, 0 -> outputs 32768, 16384, 8192.
REQ-042 Saturation: band0 b0=4.0 (131072); input 0x3000_0000 -> o_data=0x7FFF_FFFF; input 0xD000_0000 -> 0x8000_0000.
REQ-043 Commit timing: commit pulsed mid-S_MAC with new b0=0.5 -> current sample uses old b0; next sample uses 0.5.
REQ-044 Bypass and reset: i_band_en=4'b1110 with band0 b0=0.5 -> output equals input and band0 histories stay 0; i_rst asserted at cycle 7 of S_MAC -> no o_valid, o_ready=1 next cycle.
